// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls and EX-redirect squashes,
// with saturating event counters for both.
module hazard_ctrl #(
   parameter int LOAD_STALL   = 1,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        idex_memRead,
   input  logic        idex_regWrt,
   input  logic [5:0]  idex_rd,
   input  logic [5:0]  id_rs1,
   input  logic [5:0]  id_rs2,
   input  logic        id_useRs2,
   input  logic        ex_branchTaken,
   input  logic        ex_jump,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        idex_bubble,
   output logic        ifid_flush,
   output logic        busy,
   output logic [15:0] load_use_cnt,
   output logic [15:0] redirect_cnt
);

   typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

   localparam logic [1:0] STALL_LOAD  = 2'(LOAD_STALL - 1);
   localparam logic [1:0] FLUSH_LOAD  = 2'(FLUSH_CYCLES - 1);
   localparam bit         STALL_MULTI = (LOAD_STALL > 1);
   localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

   state_t     state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic       hazard, redirect, lu_inc;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // r0 is deliberately treated like any other register
   assign hazard   = idex_memRead & idex_regWrt &
                     ((idex_rd == id_rs1) | (id_useRs2 & (idex_rd == id_rs2)));
   assign redirect = ex_branchTaken | ex_jump;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      lu_inc      = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      if (redirect) begin
         // Redirect wins in every state: aborts a stall, reloads a flush
         idex_bubble = 1'b1;
         ifid_flush  = 1'b1;
         state_nxt   = FLUSH_MULTI ? FLUSH : IDLE;
         cnt_nxt     = FLUSH_LOAD;
      end else begin
         unique case (state)
            IDLE: begin
               if (hazard) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  lu_inc      = 1'b1;
                  state_nxt   = STALL_MULTI ? STALL : IDLE;
                  cnt_nxt     = STALL_LOAD;
               end
            end
            STALL: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               if (cnt <= 2'd1) begin
                  state_nxt = IDLE;
                  cnt_nxt   = 2'd0;
               end else begin
                  cnt_nxt   = cnt - 2'd1;
               end
            end
            FLUSH: begin
               idex_bubble = 1'b1;
               ifid_flush  = 1'b1;
               if (cnt <= 2'd1) begin
                  state_nxt = IDLE;
                  cnt_nxt   = 2'd0;
               end else begin
                  cnt_nxt   = cnt - 2'd1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = 2'd0;
            end
         endcase
      end
      // Reset squashes the pipe combinationally, without waiting for an edge
      if (rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         ifid_flush  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 2'd0;
         load_use_cnt <= 16'd0;
         redirect_cnt <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (lu_inc)   load_use_cnt <= sat_inc(load_use_cnt);
         if (redirect) redirect_cnt <= sat_inc(redirect_cnt);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (default and 3/3 parameters),
// expectations queued at drive time and compared at the following falling edge.
module tb_hazard_ctrl;

   localparam logic [4:0] RST_O   = 5'b00110;  // {pc_write, ifid_write, idex_bubble, ifid_flush, busy}
   localparam logic [4:0] IDLE_O  = 5'b11000;
   localparam logic [4:0] STALL_I = 5'b00100;
   localparam logic [4:0] STALL_B = 5'b00101;
   localparam logic [4:0] FLUSH_I = 5'b11110;
   localparam logic [4:0] FLUSH_B = 5'b11111;

   logic        clk, rst;
   logic        idex_memRead, idex_regWrt, id_useRs2, ex_branchTaken, ex_jump;
   logic [5:0]  idex_rd, id_rs1, id_rs2;
   logic        a_pc, a_ifid, a_bub, a_flush, a_busy;
   logic        b_pc, b_ifid, b_bub, b_flush, b_busy;
   logic [15:0] a_lu, a_rc, b_lu, b_rc;

   typedef struct packed {
      logic        inst;
      logic [4:0]  ctl;
      logic [15:0] lu;
      logic [15:0] rc;
   } exp_t;

   exp_t  sb[$];
   string tags[$];
   int    checks = 0;
   int    failures = 0;

   hazard_ctrl dut_a (
      .clk(clk), .rst(rst), .idex_memRead(idex_memRead), .idex_regWrt(idex_regWrt),
      .idex_rd(idex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs2(id_useRs2),
      .ex_branchTaken(ex_branchTaken), .ex_jump(ex_jump),
      .pc_write(a_pc), .ifid_write(a_ifid), .idex_bubble(a_bub), .ifid_flush(a_flush),
      .busy(a_busy), .load_use_cnt(a_lu), .redirect_cnt(a_rc));

   hazard_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst), .idex_memRead(idex_memRead), .idex_regWrt(idex_regWrt),
      .idex_rd(idex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs2(id_useRs2),
      .ex_branchTaken(ex_branchTaken), .ex_jump(ex_jump),
      .pc_write(b_pc), .ifid_write(b_ifid), .idex_bubble(b_bub), .ifid_flush(b_flush),
      .busy(b_busy), .load_use_cnt(b_lu), .redirect_cnt(b_rc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic inst, input logic [4:0] ctl,
                           input logic [15:0] lu, input logic [15:0] rc);
      exp_t e;
      e.inst = inst; e.ctl = ctl; e.lu = lu; e.rc = rc;
      sb.push_back(e);
      tags.push_back(tag);
   endtask

   task automatic pop_check();
      exp_t        e;
      string       t;
      logic [4:0]  oc;
      logic [15:0] ol, orc;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL sb_empty observed=0 entries required=1");
         return;
      end
      e = sb.pop_front();
      t = tags.pop_front();
      if (e.inst) begin
         oc = {b_pc, b_ifid, b_bub, b_flush, b_busy}; ol = b_lu; orc = b_rc;
      end else begin
         oc = {a_pc, a_ifid, a_bub, a_flush, a_busy}; ol = a_lu; orc = a_rc;
      end
      checks++;
      assert (oc === e.ctl) else begin
         failures++;
         $error("FAIL %s ctl observed=%b expected=%b", t, oc, e.ctl);
      end
      checks++;
      assert (ol === e.lu) else begin
         failures++;
         $error("FAIL %s load_use_cnt observed=%h expected=%h", t, ol, e.lu);
      end
      checks++;
      assert (orc === e.rc) else begin
         failures++;
         $error("FAIL %s redirect_cnt observed=%h expected=%h", t, orc, e.rc);
      end
   endtask

   // One clock cycle: expectation for the inputs already driven, check mid-cycle
   task automatic cyc(input string tag, input logic inst, input logic [4:0] ctl,
                      input logic [15:0] lu, input logic [15:0] rc);
      push_exp(tag, inst, ctl, lu, rc);
      @(negedge clk);
      pop_check();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      idex_memRead = 1'b0; idex_regWrt = 1'b0; idex_rd = 6'd0;
      id_rs1 = 6'd0; id_rs2 = 6'd0; id_useRs2 = 1'b0;
      ex_branchTaken = 1'b0; ex_jump = 1'b0;
   endtask

   task automatic haz(input logic [5:0] rd, input logic [5:0] rs1);
      idex_memRead = 1'b1; idex_regWrt = 1'b1; idex_rd = rd; id_rs1 = rs1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      clr_in();
      push_exp({tag, "_a"}, 1'b0, RST_O, 16'd0, 16'd0);
      push_exp({tag, "_b"}, 1'b1, RST_O, 16'd0, 16'd0);
      @(negedge clk);
      pop_check();
      pop_check();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clr_in();
      @(posedge clk);
      #1;
      do_reset("reset0");

      // Load-use via rs1 on the default instance
      haz(6'd5, 6'd5);
      cyc("lu_stall", 1'b0, STALL_I, 16'd0, 16'd0);
      clr_in();
      cyc("lu_after", 1'b0, IDLE_O, 16'd1, 16'd0);

      // rs2 only counts when the decode instruction reads it
      haz(6'd7, 6'd0); id_rs2 = 6'd7;
      cyc("rs2_nouse", 1'b0, IDLE_O, 16'd1, 16'd0);
      id_useRs2 = 1'b1;
      cyc("rs2_use", 1'b0, STALL_I, 16'd1, 16'd0);
      clr_in();
      cyc("rs2_after", 1'b0, IDLE_O, 16'd2, 16'd0);

      // r0 has no exclusion; a non-load producer never stalls
      haz(6'd0, 6'd0);
      cyc("r0_haz", 1'b0, STALL_I, 16'd2, 16'd0);
      clr_in();
      cyc("r0_after", 1'b0, IDLE_O, 16'd3, 16'd0);
      idex_regWrt = 1'b1; idex_rd = 6'd3; id_rs1 = 6'd3;
      cyc("no_load", 1'b0, IDLE_O, 16'd3, 16'd0);

      // Redirect and hazard together: redirect wins, hazard not counted
      clr_in();
      haz(6'd9, 6'd9); ex_branchTaken = 1'b1;
      cyc("both_0", 1'b0, FLUSH_I, 16'd3, 16'd0);
      clr_in();
      cyc("both_1", 1'b0, FLUSH_B, 16'd3, 16'd1);
      cyc("both_2", 1'b0, IDLE_O, 16'd3, 16'd1);

      do_reset("reset1");

      // Three-cycle flush from a single jump
      ex_jump = 1'b1;
      cyc("jmp_0", 1'b1, FLUSH_I, 16'd0, 16'd0);
      clr_in();
      cyc("jmp_1", 1'b1, FLUSH_B, 16'd0, 16'd1);
      cyc("jmp_2", 1'b1, FLUSH_B, 16'd0, 16'd1);
      cyc("jmp_3", 1'b1, IDLE_O, 16'd0, 16'd1);

      // Redirect inside FLUSH reloads the count; hazard ignored there
      ex_jump = 1'b1;
      cyc("rl_0", 1'b1, FLUSH_I, 16'd0, 16'd1);
      clr_in();
      cyc("rl_1", 1'b1, FLUSH_B, 16'd0, 16'd2);
      ex_jump = 1'b1; haz(6'd4, 6'd4);
      cyc("rl_2", 1'b1, FLUSH_B, 16'd0, 16'd2);
      clr_in();
      cyc("rl_3", 1'b1, FLUSH_B, 16'd0, 16'd3);
      cyc("rl_4", 1'b1, FLUSH_B, 16'd0, 16'd3);
      cyc("rl_5", 1'b1, IDLE_O, 16'd0, 16'd3);

      do_reset("reset2");

      // Full three-cycle load-use stall
      haz(6'd12, 6'd12);
      cyc("st_0", 1'b1, STALL_I, 16'd0, 16'd0);
      clr_in();
      cyc("st_1", 1'b1, STALL_B, 16'd1, 16'd0);
      cyc("st_2", 1'b1, STALL_B, 16'd1, 16'd0);
      cyc("st_3", 1'b1, IDLE_O, 16'd1, 16'd0);

      do_reset("reset3");

      // Branch aborts a stall at its second cycle
      haz(6'd20, 6'd20);
      cyc("ab_0", 1'b1, STALL_I, 16'd0, 16'd0);
      ex_branchTaken = 1'b1;
      cyc("ab_1", 1'b1, FLUSH_B, 16'd1, 16'd0);
      clr_in();
      cyc("ab_2", 1'b1, FLUSH_B, 16'd1, 16'd1);
      cyc("ab_3", 1'b1, FLUSH_B, 16'd1, 16'd1);
      cyc("ab_4", 1'b1, IDLE_O, 16'd1, 16'd1);

      // Asynchronous reset between edges in the middle of a flush
      ex_jump = 1'b1;
      cyc("ar_0", 1'b1, FLUSH_I, 16'd0 + 16'd1, 16'd1);
      clr_in();
      #2;
      push_exp("ar_pre", 1'b1, FLUSH_B, 16'd1, 16'd2);
      pop_check();
      rst = 1'b1;
      #1;
      push_exp("ar_rst", 1'b1, RST_O, 16'd0, 16'd0);
      pop_check();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("ar_post", 1'b1, IDLE_O, 16'd0, 16'd0);

      do_reset("reset4");

      // Redirect counter saturation on the default instance
      ex_jump = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      cyc("sat_fffe", 1'b0, FLUSH_B, 16'd0, 16'hFFFE);
      cyc("sat_ffff", 1'b0, FLUSH_B, 16'd0, 16'hFFFF);
      cyc("sat_hold", 1'b0, FLUSH_B, 16'd0, 16'hFFFF);
      clr_in();
      cyc("sat_end", 1'b0, FLUSH_B, 16'd0, 16'hFFFF);
      cyc("sat_idle", 1'b0, IDLE_O, 16'd0, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1, meaning load-use stall length in cycles; legal range 1..3.
REQ-002 Parameter FLUSH_CYCLES, default 2, meaning squash length in cycles after an EX redirect; legal range 1..3.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 idex_memRead  in  1  ID/EX register memReadout.
REQ-007 idex_regWrt  in  1  ID/EX register regWrtout.
REQ-008 idex_rd  in  6  ID/EX register rdOut.
REQ-009 id_rs1, id_rs2  in  6 each  source register fields of the instruction in decode.
REQ-010 id_useRs2  in  1  decode instruction reads rs2.
REQ-011 ex_branchTaken  in  1  EX branch resolved taken.
REQ-012 ex_jump  in  1  EX jump or jumpMem active.
REQ-013 pc_write  out  1  PC update enable.
REQ-014 ifid_write  out  1  IF/ID register load enable.
REQ-015 idex_bubble  out  1  force all ID/EX control inputs to 0 this cycle.
REQ-016 ifid_flush  out  1  clear IF/ID contents at next edge.
REQ-017 busy  out  1  state != IDLE.
REQ-018 load_use_cnt, redirect_cnt  out  16 each  saturating event counters.

Function
REQ-019 hazard SHALL be defined as idex_memRead & idex_regWrt & ((idex_rd==id_rs1) | (id_useRs2 & idex_rd==id_rs2)), with all 64 registers eligible and no r0 exclusion.
REQ-020 redirect SHALL be defined as ex_branchTaken | ex_jump.
REQ-021 The block SHALL implement three states: IDLE, STALL and FLUSH, plus a 2-bit down-counter cnt; outputs are combinational from state and inputs, while state and cnt are registered.
REQ-022 In IDLE with no hazard and no redirect, the outputs SHALL be pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
REQ-023 In IDLE with redirect asserted, the outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; next state SHALL be FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, otherwise IDLE.
REQ-024 When redirect and hazard are asserted in the same IDLE cycle, redirect SHALL win and the hazard SHALL be ignored.
REQ-025 In IDLE with hazard asserted and redirect deasserted, the outputs SHALL be pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; next state SHALL be STALL with cnt=LOAD_STALL-1 if LOAD_STALL>1, otherwise IDLE.
REQ-026 In STALL, the outputs SHALL equal the hazard outputs (REQ-025) and cnt SHALL decrement; the block SHALL return to IDLE on the edge where cnt==1.
REQ-027 A redirect in STALL SHALL take the REQ-023 behaviour immediately and abort the stall.
REQ-028 In FLUSH, the outputs SHALL equal the redirect outputs (REQ-023); cnt SHALL decrement and the block SHALL return to IDLE on the edge where cnt==1.
REQ-029 A redirect in FLUSH SHALL reload cnt=FLUSH_CYCLES-1 and keep the state at FLUSH; hazard SHALL be ignored in FLUSH.
REQ-030 load_use_cnt SHALL increment by 1 on each edge that takes REQ-025 from IDLE.
REQ-031 redirect_cnt SHALL increment by 1 on each edge where redirect is asserted in any state.
REQ-032 Both counters SHALL saturate at 0xFFFF and never wrap.
REQ-033 Combinational paths from the inputs to pc_write, ifid_write, idex_bubble and ifid_flush SHALL be permitted.

Reset
REQ-034 While rst=1, the block SHALL hold state=IDLE, cnt=0, load_use_cnt=0, redirect_cnt=0, busy=0.
REQ-035 While rst=1, the outputs SHALL be forced to pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1, independent of clk and the inputs.
REQ-036 Assertion of rst mid-STALL or mid-FLUSH SHALL abort immediately to the REQ-034/REQ-035 values.
REQ-037 After rst deasserts, the first rising edge SHALL evaluate from IDLE.

Verification
REQ-038 Defaults; idex_memRead=1, idex_regWrt=1, idex_rd=5, id_rs1=5 for one cycle -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle all idle values; load_use_cnt=1.
REQ-039 Defaults; hazard via rs2 with idex_rd=7, id_rs2=7, id_useRs2=0 -> no stall; repeat with id_useRs2=1 -> stall asserted.
REQ-040 FLUSH_CYCLES=3; ex_jump=1 for one cycle -> ifid_flush=1 and idex_bubble=1 for 3 consecutive cycles, busy=1 for the last 2 of them; redirect_cnt=1.
REQ-041 LOAD_STALL=3; hazard at cycle 0, ex_branchTaken=1 at cycle 1 -> STALL aborts, flush asserts at cycle 1, FLUSH runs to completion, load_use_cnt=1, redirect_cnt=1.
REQ-042 Preload redirect_cnt to 0xFFFE via 0xFFFE single-cycle redirects, then apply 2 more -> redirect_cnt holds at 0xFFFF.
REQ-043 FLUSH_CYCLES=3; assert rst asynchronously mid-FLUSH between edges -> outputs switch to the REQ-035 values without waiting for an edge; after release, state is IDLE and counters read 0.
